quad_decoder: RTL and testbench

Quadrature decoder for incremental-encoder inputs: synchronizes raw A/B channels, decodes Gray-code transitions into up/down steps, and maintains a wrapping position count. Receive-side partner of the up/down counter: it derives the direction and count events a counter consumes from a physical encoder. Sits at the board-input boundary, feeding position and step/direction to downstream control logic.

---
 rtl/quad_decoder_if.sv | 13 +
 rtl/quad_decoder.sv | 89 ++++++++
 tb/tb_quad_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder inputs, clear and decoded step/position outputs of quad_decoder
interface quad_decoder_if #(parameter int CNT_W = 8);
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] pos;
  logic             err;
  logic [7:0]       err_cnt;
  modport master (output a_in, b_in, clr, input step, dir, pos, err, err_cnt);
  modport slave  (input a_in, b_in, clr, output step, dir, pos, err, err_cnt);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder decoder with wrapping position count; optional glitch filter via QDEC_FILTER_EN
module quad_decoder #(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3
) (
  input logic           clk,
  input logic           rst,
  quad_decoder_if.slave bus
);
  typedef enum logic {PRIME, RUN} state_t;
  state_t           r_state;
  logic [1:0]       r_sync1, r_sync2, r_prv;
  logic [2:0]       r_fill;
  logic             r_step, r_dir, r_err;
  logic [CNT_W-1:0] r_pos;
  logic [7:0]       r_err_cnt;
  logic [1:0]       w_cur, w_pi, w_ci, w_d;
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("FILT_LEN must be 1..15");
  end
`ifdef QDEC_FILTER_EN
  logic [1:0] r_flt;
  logic [3:0] r_fcnt [2];
  // per-channel stability counter: a new level is accepted after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flt <= '0;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_state == PRIME || r_sync2[i] == r_flt[i]) begin
          r_flt[i]  <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == 4'(FILT_LEN - 1)) begin
          r_flt[i]  <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end
  assign w_cur = r_flt;
`else
  assign w_cur = r_sync2;
`endif
  // Gray state {A,B} mapped to a 0..3 phase; the phase delta gives up(1), down(3), illegal(2)
  assign w_pi = {r_prv[0], ^r_prv};
  assign w_ci = {w_cur[0], ^w_cur};
  assign w_d  = w_ci - w_pi;
  // synchronizer, priming FSM and decode; PRIME is held until the input pipeline carries real samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_fill    <= '0;
      r_prv     <= '0;
      r_state   <= PRIME;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_sync1 <= {bus.a_in, bus.b_in};
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[1:0], 1'b1};
      r_prv   <= w_cur;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == PRIME) begin
        if (r_fill[2]) r_state <= RUN;
      end else if (w_d == 2'd1 || w_d == 2'd3) begin
        r_step <= 1'b1;
        r_dir  <= w_d == 2'd1;
        r_pos  <= w_d == 2'd1 ? r_pos + 1'b1 : r_pos - 1'b1;
      end else if (w_d == 2'd2) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (bus.clr) r_pos <= '0;
    end
  end
  assign bus.step    = r_step;
  assign bus.dir     = r_dir;
  assign bus.pos     = r_pos;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed-vector self-checking bench for quad_decoder
module tb_quad_decoder;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 6;
  localparam int HOLD = 8;
`else
  localparam int LAT = 3;
  localparam int HOLD = 8;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n_step = 0;
  int   n_err = 0;
  int   n_both = 0;
  int   s0, e0;
  quad_decoder_if #(.CNT_W(8)) bus ();
  quad_decoder #(.CNT_W(8), .FILT_LEN(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // pulse counters sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.step) n_step++;
    if (bus.err) n_err++;
    if (bus.step && bus.err) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drv(input logic [1:0] ab, input int n);
    {bus.a_in, bus.b_in} = ab;
    tick(n);
  endtask
  initial begin
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    bus.clr  = 1'b0;
    tick(3);
    chk("rst_pos", bus.pos, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_errcnt", bus.err_cnt, 0);
    chk("rst_dir", bus.dir, 0);
    rst = 1'b1;
    tick(12);
    chk("prime_nstep", n_step, 0);
    chk("prime_nerr", n_err, 0);
    chk("prime_pos", bus.pos, 0);
    chk("prime_errcnt", bus.err_cnt, 0);
    rst = 1'b0;
    drv(2'b00, 2);
    rst = 1'b1;
    tick(10);
    s0 = n_step;
    drv(2'b10, LAT - 1);
    chk("lat_early", bus.step, 0);
    tick(1);
    chk("lat_step", bus.step, 1);
    chk("lat_dir", bus.dir, 1);
    chk("lat_pos", bus.pos, 1);
    tick(1);
    chk("lat_pulse", bus.step, 0);
    tick(HOLD - LAT - 1);
    drv(2'b11, HOLD);
    drv(2'b01, HOLD);
    drv(2'b00, HOLD);
    drv(2'b10, HOLD);
    drv(2'b11, HOLD);
    drv(2'b01, HOLD);
    drv(2'b00, HOLD);
    chk("up_nstep", n_step - s0, 8);
    chk("up_pos", bus.pos, 8);
    chk("up_dir", bus.dir, 1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(1);
    chk("clr_pos", bus.pos, 0);
    chk("clr_dir", bus.dir, 1);
    s0 = n_step;
    drv(2'b01, HOLD);
    drv(2'b11, HOLD);
    drv(2'b10, HOLD);
    chk("dn_nstep", n_step - s0, 3);
    chk("dn_pos", bus.pos, 253);
    chk("dn_dir", bus.dir, 0);
    drv(2'b11, HOLD);
    drv(2'b01, HOLD);
    chk("wrap_255", bus.pos, 255);
    drv(2'b00, HOLD);
    chk("wrap_0", bus.pos, 0);
    chk("wrap_dir", bus.dir, 1);
    e0 = n_err;
    s0 = n_step;
    drv(2'b11, HOLD);
    chk("ill_nerr", n_err - e0, 1);
    chk("ill_nstep", n_step - s0, 0);
    chk("ill_pos", bus.pos, 0);
    chk("ill_errcnt", bus.err_cnt, 1);
    chk("ill_dir", bus.dir, 1);
    for (int i = 0; i < 299; i++) drv((i % 2 == 0) ? 2'b00 : 2'b11, 5);
    tick(LAT + 2);
    chk("sat_nerr", n_err - e0, 300);
    chk("sat_errcnt", bus.err_cnt, 255);
    chk("sat_pos", bus.pos, 0);
    chk("sat_nstep", n_step - s0, 0);
    drv(2'b10, HOLD);
    drv(2'b11, HOLD);
    drv(2'b01, HOLD);
    drv(2'b00, HOLD);
    drv(2'b10, HOLD);
    chk("pre_clr_pos", bus.pos, 5);
    drv(2'b11, LAT - 1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("coll_pos", bus.pos, 0);
    chk("coll_step", bus.step, 1);
    chk("coll_dir", bus.dir, 1);
    tick(4);
    chk("coll_hold", bus.pos, 0);
    chk("coll_errcnt", bus.err_cnt, 255);
`ifdef QDEC_FILTER_EN
    s0 = n_step;
    e0 = n_err;
    drv(2'b01, 2);
    drv(2'b11, 10);
    chk("glitch_nstep", n_step - s0, 0);
    chk("glitch_nerr", n_err - e0, 0);
    drv(2'b01, 5);
    chk("filt_early", bus.step, 0);
    tick(1);
    chk("filt_step", bus.step, 1);
    chk("filt_pos", bus.pos, 1);
    tick(4);
`endif
    chk("both_never", n_both, 0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("mid_rst_pos", bus.pos, 0);
    chk("mid_rst_errcnt", bus.err_cnt, 0);
    chk("mid_rst_dir", bus.dir, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
